// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM decode encodings, condition evaluation and the ID/EX control bundle.
package arm_pkg;
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic        imm;
        logic [11:0] shift_op;
        logic [23:0] simm24;
    } idex_bundle_t;

    // sr is {N,Z,C,V}; NV never executes
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v;
        {n, z, c, v} = sr;
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/arm_regfile.sv
// arm_regfile: two-read, one-write register file with optional same-cycle writeback bypass.
module arm_regfile #(
    parameter int DATA_W    = 32,
    parameter int REG_N     = 16,
    parameter int BYPASS_WB = 1,
    localparam int ADDR_W   = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs [REG_N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs <= '{default: '0};
        else if (wb_en) regs[wb_dest] <= wb_value;
    end

    assign rd1 = (BYPASS_WB != 0 && wb_en && wb_dest == ra1) ? wb_value : regs[ra1];
    assign rd2 = (BYPASS_WB != 0 && wb_en && wb_dest == ra2) ? wb_value : regs[ra2];
endmodule

// File: rtl/id_stage_param.sv
// id_stage_param: ARM decode stage with register file, condition check, hazard stall
// and a bubble-able ID/EX pipeline register.
module id_stage_param
    import arm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_N     = 16,
    parameter int BYPASS_WB = 1,
    parameter int FWD_EN    = 0,
    localparam int ADDR_W   = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic              flush,
    input  logic [3:0]        sr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [ADDR_W-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic [3:0]        ex_exe_cmd,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic              ex_imm,
    output logic [11:0]       ex_shift_op,
    output logic [23:0]       ex_simm24,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [ADDR_W-1:0] ex_src1,
    output logic [ADDR_W-1:0] ex_src2
);
    logic [1:0]        mode;
    logic [3:0]        op;
    logic              s_bit, is_str, two_src, uses_rn, cond_ok, hazard, bubble;
    logic              exe_hit1, exe_hit2, mem_hit1, mem_hit2;
    logic [ADDR_W-1:0] src1, src2, dest;
    logic [DATA_W-1:0] val_rn, val_rm;
    idex_bundle_t      dec, ld, ex_q;

    assign mode    = instr[27:26];
    assign op      = instr[24:21];
    assign s_bit   = instr[20];
    assign is_str  = mode == MODE_MEM && !s_bit;
    assign src1    = ADDR_W'(instr[19:16]);
    assign dest    = ADDR_W'(instr[15:12]);
    assign src2    = is_str ? dest : ADDR_W'(instr[3:0]);
    assign two_src = is_str || !instr[25];
    assign uses_rn = !(mode == MODE_BR || (mode == MODE_DP && (op == OP_MOV || op == OP_MVN)));
    assign cond_ok = cond_check(instr[31:28], sr);

    arm_regfile #(.DATA_W(DATA_W), .REG_N(REG_N), .BYPASS_WB(BYPASS_WB)) u_rf (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .ra1(src1), .ra2(src2), .rd1(val_rn), .rd2(val_rm)
    );

    // With forwarding only an EXE load result is unavailable in time
    assign exe_hit1 = exe_wb_en && (FWD_EN == 0 || exe_mem_r_en) && exe_dest == src1;
    assign exe_hit2 = exe_wb_en && (FWD_EN == 0 || exe_mem_r_en) && exe_dest == src2;
    assign mem_hit1 = FWD_EN == 0 && mem_wb_en && mem_dest == src1;
    assign mem_hit2 = FWD_EN == 0 && mem_wb_en && mem_dest == src2;
    assign hazard   = instr_valid && ((uses_rn && (exe_hit1 || mem_hit1)) ||
                                      (two_src && (exe_hit2 || mem_hit2)));
    assign stall    = hazard && !flush;
    assign bubble   = flush || stall;

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.imm      = instr[25];
        dec.shift_op = instr[11:0];
        dec.simm24   = instr[23:0];
        case (mode)
            MODE_DP: begin
                dec.wb_en = 1'b1;
                dec.s     = s_bit;
                case (op)
                    OP_MOV: dec.exe_cmd = CMD_MOV;
                    OP_MVN: dec.exe_cmd = CMD_MVN;
                    OP_ADD: dec.exe_cmd = CMD_ADD;
                    OP_ADC: dec.exe_cmd = CMD_ADC;
                    OP_SUB: dec.exe_cmd = CMD_SUB;
                    OP_SBC: dec.exe_cmd = CMD_SBC;
                    OP_AND: dec.exe_cmd = CMD_AND;
                    OP_ORR: dec.exe_cmd = CMD_ORR;
                    OP_EOR: dec.exe_cmd = CMD_EOR;
                    OP_CMP: begin dec.exe_cmd = CMD_SUB; dec.wb_en = 1'b0; dec.s = 1'b1; end
                    OP_TST: begin dec.exe_cmd = CMD_AND; dec.wb_en = 1'b0; dec.s = 1'b1; end
                    default: dec.wb_en = 1'b0;
                endcase
            end
            MODE_MEM: begin
                dec.exe_cmd  = CMD_ADD;
                dec.mem_r_en = s_bit;
                dec.wb_en    = s_bit;
                dec.mem_w_en = !s_bit;
            end
            MODE_BR: dec.b = 1'b1;
            default: ;
        endcase
        ld = dec;
        if (!(cond_ok && instr_valid)) {ld.valid, ld.wb_en, ld.mem_r_en, ld.mem_w_en, ld.b, ld.s} = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q      <= '0;
            ex_val_rn <= '0;
            ex_val_rm <= '0;
            ex_dest   <= '0;
            ex_src1   <= '0;
            ex_src2   <= '0;
        end else begin
            ex_q      <= bubble ? '0 : ld;
            ex_val_rn <= bubble ? '0 : val_rn;
            ex_val_rm <= bubble ? '0 : val_rm;
            ex_dest   <= bubble ? '0 : dest;
            ex_src1   <= bubble ? '0 : src1;
            ex_src2   <= bubble ? '0 : src2;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_wb_en    = ex_q.wb_en;
    assign ex_mem_r_en = ex_q.mem_r_en;
    assign ex_mem_w_en = ex_q.mem_w_en;
    assign ex_b        = ex_q.b;
    assign ex_s        = ex_q.s;
    assign ex_exe_cmd  = ex_q.exe_cmd;
    assign ex_imm      = ex_q.imm;
    assign ex_shift_op = ex_q.shift_op;
    assign ex_simm24   = ex_q.simm24;
endmodule

// File: tb/tb_id_stage_param.sv
// tb_id_stage_param: vector table plus scoreboard for two configurations
// (no forwarding with WB bypass, and forwarding without WB bypass).
module tb_id_stage_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid, flush, wb_en, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic [3:0]  sr, wb_dest, exe_dest, mem_dest;
    logic [31:0] wb_value;

    logic        stall, ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
    logic [3:0]  ex_exe_cmd, ex_dest, ex_src1, ex_src2;
    logic [31:0] ex_val_rn, ex_val_rm;
    logic [11:0] ex_shift_op;
    logic [23:0] ex_simm24;

    logic        f_stall, f_valid, f_wb_en, f_mem_r_en, f_mem_w_en, f_b, f_s, f_imm;
    logic [3:0]  f_exe_cmd, f_dest, f_src1, f_src2;
    logic [31:0] f_val_rn, f_val_rm;
    logic [11:0] f_shift_op;
    logic [23:0] f_simm24;

    int total = 0, passed = 0;

    always #5 clk = ~clk;

    id_stage_param dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush), .sr(sr),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .stall(stall),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd),
        .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_imm(ex_imm), .ex_shift_op(ex_shift_op),
        .ex_simm24(ex_simm24), .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
    );

    id_stage_param #(.FWD_EN(1), .BYPASS_WB(0)) dut_fwd (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush), .sr(sr),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .stall(f_stall),
        .ex_valid(f_valid), .ex_wb_en(f_wb_en), .ex_mem_r_en(f_mem_r_en),
        .ex_mem_w_en(f_mem_w_en), .ex_b(f_b), .ex_s(f_s), .ex_exe_cmd(f_exe_cmd),
        .ex_val_rn(f_val_rn), .ex_val_rm(f_val_rm), .ex_imm(f_imm), .ex_shift_op(f_shift_op),
        .ex_simm24(f_simm24), .ex_dest(f_dest), .ex_src1(f_src1), .ex_src2(f_src2)
    );

    typedef struct {
        logic [31:0] instr;
        logic        iv, fl;
        logic [3:0]  sr, ed;
        logic        ew, emr;
        logic [3:0]  md;
        logic        mw, we;
        logic [3:0]  wd;
        logic [31:0] wv;
        logic        st0, st1;
        logic [9:0]  ctrl;
        logic [31:0] rn, rm;
        logic [3:0]  dest;
        logic        v1;
        logic [31:0] rm1;
    } vec_t;

    // ctrl = {valid, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}
    localparam int K_BUB = 0;
    localparam int K_ADD = {6'b110000, 4'b0010};
    localparam int K_NOK = {6'b000000, 4'b0010};
    localparam int K_MOV = {6'b110000, 4'b0001};
    localparam int K_SUB = {6'b110000, 4'b0100};
    localparam int K_CMP = {6'b100001, 4'b0100};
    localparam int K_LDR = {6'b111000, 4'b0010};
    localparam int K_STR = {6'b100100, 4'b0010};
    localparam int K_B   = {6'b100010, 4'b0000};

    localparam int I_R5    = 32'hE0850005; // ADD R0,R5,R5
    localparam int I_ADD   = 32'hE0821003; // ADD R1,R2,R3
    localparam int I_ADDEQ = 32'h00821003;
    localparam int I_NV    = 32'hF0821003;
    localparam int I_MOV   = 32'hE1A05003; // MOV R5,R3
    localparam int I_SUB   = 32'hE2424001; // SUB R4,R2,#1
    localparam int I_CMP   = 32'hE1520003; // CMP R2,R3
    localparam int I_LDR   = 32'hE5926004; // LDR R6,[R2,#4]
    localparam int I_STR   = 32'hE5823008; // STR R3,[R2,#8]
    localparam int I_B     = 32'hEA000010;

    function automatic vec_t mk(input int ins, iv, fl, s, ed, ew, emr, md, mw, we, wd, wv,
                                st0, st1, ctrl, rn, rm, dest, v1, rm1);
        vec_t v;
        v.instr = 32'(ins); v.iv = 1'(iv); v.fl = 1'(fl); v.sr = 4'(s);
        v.ed = 4'(ed); v.ew = 1'(ew); v.emr = 1'(emr); v.md = 4'(md); v.mw = 1'(mw);
        v.we = 1'(we); v.wd = 4'(wd); v.wv = 32'(wv); v.st0 = 1'(st0); v.st1 = 1'(st1);
        v.ctrl = 10'(ctrl); v.rn = 32'(rn); v.rm = 32'(rm); v.dest = 4'(dest);
        v.v1 = 1'(v1); v.rm1 = 32'(rm1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic idle();
        instr = 0; instr_valid = 0; flush = 0; sr = 0; wb_en = 0; wb_dest = 0; wb_value = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
    endtask

    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;

    initial begin
        //          instr    iv fl sr ed ew emr md mw we wd wv    st0 st1 ctrl   rn rm    dest v1 rm1
        vecs.push_back(mk(I_R5,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_ADD, 0, 0,    0, 1, 0));
        vecs.push_back(mk(0,      0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 7,    0, 0, K_BUB, 0, 0,    0, 0, 0));
        vecs.push_back(mk(0,      0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 5,    0, 0, K_BUB, 0, 0,    0, 0, 0));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_ADD, 7, 5,    1, 1, 5));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0,    1, 0, K_BUB, 0, 0,    0, 1, 5));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0,    1, 1, K_BUB, 0, 0,    0, 0, 0));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0,    1, 0, K_BUB, 0, 0,    0, 1, 5));
        vecs.push_back(mk(I_ADD,  1, 1, 0, 2, 1, 1, 3, 1, 0, 0, 0,    0, 0, K_BUB, 0, 0,    0, 0, 0));
        vecs.push_back(mk(I_ADDEQ,1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_NOK, 7, 5,    1, 0, 5));
        vecs.push_back(mk(I_ADDEQ,1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_ADD, 7, 5,    1, 1, 5));
        vecs.push_back(mk(I_NV,   1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_NOK, 7, 5,    1, 0, 5));
        vecs.push_back(mk(I_MOV,  1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,    0, 0, K_MOV, 0, 5,    5, 1, 5));
        vecs.push_back(mk(I_SUB,  1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0,    0, 0, K_SUB, 7, 0,    4, 1, 0));
        vecs.push_back(mk(I_CMP,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_CMP, 7, 5,    0, 1, 5));
        vecs.push_back(mk(I_LDR,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_LDR, 7, 0,    6, 1, 0));
        vecs.push_back(mk(I_STR,  1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0,    1, 0, K_BUB, 0, 0,    0, 1, 5));
        vecs.push_back(mk(I_STR,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_STR, 7, 5,    3, 1, 5));
        vecs.push_back(mk(I_B,    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_B,   0, 0,    0, 1, 0));
        vecs.push_back(mk(I_ADD,  0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0,    0, 0, K_NOK, 7, 5,    1, 0, 5));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h55, 0, 0, K_ADD, 7, 'h55, 1, 1, 5));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_ADD, 7, 'h55, 1, 1, 'h55));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 2, 1, 1, 0, 0, 1, 2, 9,    1, 1, K_BUB, 0, 0,    0, 0, 0));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, K_ADD, 9, 'h55, 1, 1, 'h55));

        idle();
        flush = 1;
        rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_ctrl", 32'({ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd}), 0);
        chk("rst_vals", ex_val_rn | ex_val_rm, 0);
        chk("rst_fields", 32'({ex_imm, ex_shift_op, ex_dest, ex_src1, ex_src2}), 0);
        chk("rst_simm", 32'(ex_simm24), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_valid", 32'(f_valid), 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            instr = vecs[i].instr; instr_valid = vecs[i].iv; flush = vecs[i].fl; sr = vecs[i].sr;
            exe_dest = vecs[i].ed; exe_wb_en = vecs[i].ew; exe_mem_r_en = vecs[i].emr;
            mem_dest = vecs[i].md; mem_wb_en = vecs[i].mw;
            wb_en = vecs[i].we; wb_dest = vecs[i].wd; wb_value = vecs[i].wv;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].st0));
            chk($sformatf("v%0d_stall_fwd", i), 32'(f_stall), 32'(vecs[i].st1));
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_ctrl", i),
                32'({ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd}), 32'(e.ctrl));
            chk($sformatf("v%0d_rn", i), ex_val_rn, e.rn);
            chk($sformatf("v%0d_rm", i), ex_val_rm, e.rm);
            chk($sformatf("v%0d_dest", i), 32'(ex_dest), 32'(e.dest));
            chk($sformatf("v%0d_valid_fwd", i), 32'(f_valid), 32'(e.v1));
            chk($sformatf("v%0d_rm_fwd", i), f_val_rm, e.rm1);
        end

        // branch bundle carries the raw offset and immediate bit
        @(negedge clk);
        idle();
        instr = I_B; instr_valid = 1;
        @(posedge clk);
        #1;
        chk("b_simm24", 32'(ex_simm24), 32'h000010);
        chk("b_imm", 32'(ex_imm), 1);

        // asynchronous reset mid-operation discards the bundle and the register file
        @(negedge clk);
        idle();
        instr = I_ADD; instr_valid = 1;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(ex_valid), 1);
        chk("pre_rst_rn", ex_val_rn, 9);
        #2;
        rst = 0;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 0);
        chk("async_rst_rn", ex_val_rn, 0);
        chk("async_rst_fwd_valid", 32'(f_valid), 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(ex_valid), 1);
        chk("post_rst_rn", ex_val_rn, 0);
        chk("post_rst_rm", ex_val_rm, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
